iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter W, default 8, giving the datapath width in bits (legal range 4..32).
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port InValid, input, 1, meaning the operands and OP are presented.
REQ-005 SHALL have port InReady, output, 1, meaning the block accepts an operation this cycle.
REQ-006 SHALL have ports InputA and InputB, input, W, the unsigned operands.
REQ-007 SHALL have port OP, input, 3, with encoding 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-008 SHALL have port OutValid, output, 1, meaning the result and flags are valid.
REQ-009 SHALL have port OutReady, input, 1, meaning the consumer takes the result this cycle.
REQ-010 SHALL have port Out, output, W, the registered result.
REQ-011 SHALL have ports Zero, LT and Carry, output, 1 each, the registered flags.

Function
REQ-012 SHALL have FSM states IDLE, BUSY and DONE; InReady = (state==IDLE) && !Reset.
REQ-013 Accept on InValid && InReady; InputA, InputB and OP latched at accept; later input changes ignored.
REQ-014 ADD, SUB, AND, OR, XOR, SHL and SHR: IDLE->DONE at accept; OutValid high the next cycle (latency 1).
REQ-015 ADD: Out = (A+B) mod 2^W; Carry = carry-out of bit W-1.
REQ-016 SUB: Out = (A-B) mod 2^W (wrap, A<B gives 2^W-B+A); Carry = borrow (A<B).
REQ-017 SHL/SHR: logical shift of A by B[clog2(W)-1:0]; Carry = last bit shifted out (0 if the shift amount is 0).
REQ-018 AND/OR/XOR: Carry = 0.
REQ-019 MUL (with MULT_EN): IDLE->BUSY at accept, W shift-add iterations, BUSY->DONE; OutValid asserts exactly W+1 cycles after accept.
REQ-020 MUL: Out = low W bits of A*B; Carry = 1 iff the high W bits are nonzero.
REQ-021 LT = (A<B) unsigned, computed from the latched operands for every OP.
REQ-022 Zero = (Out==0), registered together with Out.
REQ-023 In DONE, Out, Zero, LT, Carry and OutValid stay stable until OutReady; DONE && OutReady -> IDLE.
REQ-024 No bypass: a new operation is accepted no earlier than the cycle after the result is consumed; one operation in flight.
REQ-025 InValid is ignored in BUSY and DONE; OutReady is ignored when OutValid=0.

Reset
REQ-026 Reset SHALL force state to IDLE, clear OutValid, Out, Zero, LT and Carry to 0, and hold InReady at 0 while asserted.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation and discard the result; no OutValid follows.
REQ-028 InReady SHALL be 1 in the first cycle after Reset deasserts.

Configuration
REQ-029 Macro ITER_ALU_MULT_EN defined SHALL include the iterative multiplier and the MUL behaviour of REQ-019/020.
REQ-030 Without ITER_ALU_MULT_EN, OP=111 SHALL complete in 1 cycle with Out=0, Zero=1, Carry=0, LT per REQ-021, and no BUSY state is reachable.

Structure
REQ-031 Package alu_pkg SHALL hold the OP encoding constants, the FSM state typedef and the default width.
REQ-032 Sub-module iter_mul (shift-add, start/done, parameter W) SHALL implement MUL; instantiated only under ITER_ALU_MULT_EN.

Verification
REQ-033 W=8, ADD A=200 B=100 -> one cycle after accept Out=44, Carry=1, Zero=0, LT=0.
REQ-034 W=8, SUB A=5 B=10 -> Out=251, Carry=1, LT=1; SUB A=7 B=7 -> Out=0, Zero=1, Carry=0.
REQ-035 W=8, MUL A=20 B=13 -> OutValid exactly 9 cycles after accept, Out=4, Carry=1; InReady=0 throughout.
REQ-036 Result held with OutReady=0 for 5 cycles while InValid pulses -> Out and flags unchanged, no accept; OutReady=1 -> IDLE the next cycle.
REQ-037 Reset pulsed 3 cycles into MUL -> OutValid never asserts, all outputs 0, InReady=1 the cycle after Reset falls.
REQ-038 W=16, SHL A=16'h8001 B=1 -> Out=16'h0002, Carry=1; rerun REQ-035 without ITER_ALU_MULT_EN -> Out=0, Zero=1, OutValid after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for iter_alu: operation encoding, FSM state type, default width.
package alu_pkg;

  localparam int ALU_DEFAULT_W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iter_mul.sv
// Shift-add unsigned multiplier: one partial product per cycle, the first taken at start.
// done is high for one cycle, W-1 cycles after start, with the full 2W-bit product on product.
module iter_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W + 1);

  logic           busy;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  assign done    = busy && (cnt == '0);
  assign product = acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      // Bit 0 is folded into the load so the product lands one cycle earlier.
      busy   <= 1'b1;
      acc    <= b[0] ? {{W{1'b0}}, a} : '0;
      mcand  <= {{W{1'b0}}, a} << 1;
      mplier <= b >> 1;
      cnt    <= CW'(W - 1);
    end else if (busy) begin
      if (cnt != '0) begin
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end else begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Single-issue ALU with valid/ready handshakes; simple ops finish in 1 cycle.
// ITER_ALU_MULT_EN adds an iterative MUL (W+1 cycles); without it MUL returns 0 in 1 cycle.
module iter_alu
  import alu_pkg::*;
#(
  parameter int W = ALU_DEFAULT_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  input  logic [2:0]   OP,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [W-1:0] Out,
  output logic         Zero,
  output logic         LT,
  output logic         Carry
);

  localparam int SW = $clog2(W);

  state_t         state;
  logic           accept;
  logic [W-1:0]   res;
  logic           res_c;
  logic [W:0]     shl_w;
  logic [W:0]     shr_w;
  logic [SW-1:0]  sh;
  logic           mul_done;
  logic [2*W-1:0] prod;
  logic           lt_pend;

  assign InReady = (state == IDLE) && !Reset;
  assign accept  = InValid && InReady;
  assign sh      = InputB[SW-1:0];

`ifdef ITER_ALU_MULT_EN
  localparam bit MUL_EN = 1'b1;
  logic mul_start;
  assign mul_start = accept && (OP == OP_MUL);

  iter_mul #(.W(W)) u_mul (
    .clk     (Clk),
    .reset   (Reset),
    .start   (mul_start),
    .a       (InputA),
    .b       (InputB),
    .done    (mul_done),
    .product (prod)
  );
`else
  localparam bit MUL_EN = 1'b0;
  assign mul_done = 1'b0;
  assign prod     = '0;
`endif

  // The extra bit of each shift window catches the last bit shifted out.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    shl_w = {1'b0, InputA} << sh;
    shr_w = {InputA, 1'b0} >> sh;
    case (OP)
      OP_ADD:  {res_c, res} = {1'b0, InputA} + {1'b0, InputB};
      OP_SUB:  begin
        res   = InputA - InputB;
        res_c = InputA < InputB;
      end
      OP_AND:  res = InputA & InputB;
      OP_OR:   res = InputA | InputB;
      OP_XOR:  res = InputA ^ InputB;
      OP_SHL:  {res_c, res} = shl_w;
      OP_SHR:  {res, res_c} = shr_w;
      default: res = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      OutValid <= 1'b0;
      Out      <= '0;
      Zero     <= 1'b0;
      LT       <= 1'b0;
      Carry    <= 1'b0;
      lt_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (MUL_EN && (OP == OP_MUL)) begin
            state   <= BUSY;
            lt_pend <= InputA < InputB;
          end else begin
            state    <= DONE;
            OutValid <= 1'b1;
            Out      <= res;
            Zero     <= (res == '0);
            LT       <= InputA < InputB;
            Carry    <= res_c;
          end
        end
        BUSY: if (mul_done) begin
          state    <= DONE;
          OutValid <= 1'b1;
          Out      <= prod[W-1:0];
          Zero     <= (prod[W-1:0] == '0);
          LT       <= lt_pend;
          Carry    <= |prod[2*W-1:W];
        end
        DONE: if (OutReady) begin
          state    <= IDLE;
          OutValid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Directed vector bench for iter_alu (W=8) plus a W=16 instance for shift corner cases.
module tb_iter_alu;
  import alu_pkg::*;

`ifdef ITER_ALU_MULT_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       InValid, OutReady;
  logic       InReady, OutValid, Zero, LT, Carry;
  logic [7:0] InputA, InputB, Out;
  logic [2:0] OP;

  logic        in_valid16, out_ready16;
  logic        in_ready16, out_valid16, zero16, lt16, carry16;
  logic [15:0] a16, b16, out16;
  logic [2:0]  op16;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  iter_alu #(.W(8)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InputA(InputA), .InputB(InputB), .OP(OP), .OutValid(OutValid),
    .OutReady(OutReady), .Out(Out), .Zero(Zero), .LT(LT), .Carry(Carry)
  );

  iter_alu #(.W(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .InValid(in_valid16), .InReady(in_ready16),
    .InputA(a16), .InputB(b16), .OP(op16), .OutValid(out_valid16),
    .OutReady(out_ready16), .Out(out16), .Zero(zero16), .LT(lt16), .Carry(carry16)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       z;
    logic       lt;
    logic       c;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one op on the W=8 DUT; returns cycles from accept edge to OutValid.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output bit rdy_seen);
    @(negedge Clk);
    InputA = a; InputB = b; OP = op; InValid = 1'b1;
    chk("in_ready_at_issue", InReady, 1);
    @(negedge Clk);
    InValid = 1'b0; InputA = ~a; InputB = ~b; OP = ~op;
    lat = 1;
    rdy_seen = 1'b0;
    while (!OutValid && lat < 40) begin
      if (InReady) rdy_seen = 1'b1;
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic consume();
    OutReady = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0;
    chk("idle_after_consume_ready", InReady, 1);
    chk("idle_after_consume_valid", OutValid, 0);
  endtask

  initial begin
    int  lat;
    bit  rdy_seen;
    bit  hold_bad;

    vecs[0]  = '{OP_ADD, 8'd200, 8'd100, 8'd44,  1'b0, 1'b0, 1'b1, 1};
    vecs[1]  = '{OP_SUB, 8'd5,   8'd10,  8'd251, 1'b0, 1'b1, 1'b1, 1};
    vecs[2]  = '{OP_SUB, 8'd7,   8'd7,   8'd0,   1'b1, 1'b0, 1'b0, 1};
    vecs[3]  = '{OP_AND, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{OP_OR,  8'h0F,  8'hF0,  8'hFF,  1'b0, 1'b1, 1'b0, 1};
    vecs[5]  = '{OP_XOR, 8'hAA,  8'hAA,  8'h00,  1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{OP_SHL, 8'h81,  8'h01,  8'h02,  1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{OP_SHL, 8'h81,  8'h00,  8'h81,  1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{OP_SHR, 8'h81,  8'h01,  8'h40,  1'b0, 1'b0, 1'b1, 1};
    vecs[9]  = '{OP_SHR, 8'h81,  8'h0B,  8'h10,  1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{OP_ADD, 8'd255, 8'd1,   8'd0,   1'b1, 1'b0, 1'b1, 1};
    vecs[11] = '{OP_MUL, 8'd20,  8'd13,  MUL_EN ? 8'd4 : 8'd0, !MUL_EN, 1'b0, MUL_EN, MUL_EN ? 9 : 1};
    vecs[12] = '{OP_MUL, 8'd16,  8'd16,  8'd0,   1'b1, 1'b0, MUL_EN, MUL_EN ? 9 : 1};
    vecs[13] = '{OP_MUL, 8'd3,   8'd5,   MUL_EN ? 8'd15 : 8'd0, !MUL_EN, 1'b1, 1'b0, MUL_EN ? 9 : 1};

    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    InputA = '0; InputB = '0; OP = OP_ADD;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; op16 = OP_ADD;
    repeat (3) @(negedge Clk);
    chk("reset_in_ready", InReady, 0);
    chk("reset_out_valid", OutValid, 0);
    chk("reset_out", Out, 0);
    chk("reset_flags", {Zero, LT, Carry}, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("in_ready_after_reset", InReady, 1);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, rdy_seen);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_out", i), Out, vecs[i].out);
      chk($sformatf("v%0d_zero", i), Zero, vecs[i].z);
      chk($sformatf("v%0d_lt", i), LT, vecs[i].lt);
      chk($sformatf("v%0d_carry", i), Carry, vecs[i].c);
      chk($sformatf("v%0d_in_ready_low_while_busy", i), rdy_seen, 0);
      consume();
    end

    // Result must hold while the consumer stalls, even with InValid pulsing.
    issue(OP_ADD, 8'd200, 8'd100, lat, rdy_seen);
    chk("hold_latency", lat, 1);
    hold_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      InValid = i[0]; InputA = 8'd1; InputB = 8'd2; OP = OP_SUB;
      @(negedge Clk);
      if (Out !== 8'd44 || Carry !== 1'b1 || Zero !== 1'b0 || LT !== 1'b0 ||
          OutValid !== 1'b1 || InReady !== 1'b0) hold_bad = 1'b1;
    end
    InValid = 1'b0;
    chk("hold_stable", hold_bad, 0);
    consume();
    repeat (3) @(negedge Clk);
    chk("no_accept_during_hold", OutValid, 0);

    // Reset pulsed three cycles into a MUL discards it entirely.
    issue(OP_ADD, 8'd0, 8'd0, lat, rdy_seen);
    consume();
    @(negedge Clk);
    InputA = 8'd20; InputB = 8'd13; OP = OP_MUL; InValid = 1'b1;
    @(negedge Clk);
    InValid = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_in_ready_in_reset", InReady, 0);
    chk("abort_out_cleared", {OutValid, Out, Zero, LT, Carry}, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_in_ready_after", InReady, 1);
    hold_bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (OutValid !== 1'b0 || Out !== 8'd0) hold_bad = 1'b1;
      @(negedge Clk);
    end
    chk("abort_no_result", hold_bad, 0);

    // W=16 shifts: carry from the MSB, and upper B bits ignored in the shift amount.
    @(negedge Clk);
    a16 = 16'h8001; b16 = 16'd1; op16 = OP_SHL; in_valid16 = 1'b1;
    @(negedge Clk);
    in_valid16 = 1'b0;
    chk("w16_shl_valid", out_valid16, 1);
    chk("w16_shl_out", out16, 16'h0002);
    chk("w16_shl_carry", carry16, 1);
    out_ready16 = 1'b1;
    @(negedge Clk);
    out_ready16 = 1'b0;
    a16 = 16'h8001; b16 = 16'h0010; op16 = OP_SHR; in_valid16 = 1'b1;
    @(negedge Clk);
    in_valid16 = 1'b0;
    chk("w16_shr0_out", out16, 16'h8001);
    chk("w16_shr0_carry", carry16, 0);
    chk("w16_shr0_lt", lt16, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
